serial_word_deserializer: RTL and testbench
===========================================

// Module: serial_word_deserializer
// PURPOSE
//  Receive side of the serial path fed by the universal shift register's serial outputs.
//  Collects a qualified serial bit stream into WIDTH-bit parallel words.
//  Presents each word on a one-entry valid/ready output buffer and flags overrun.
//  Sits between a shift-register serial output and any parallel consumer.
// PARAMETERS
//  WIDTH      4  bits per word; WIDTH >= 2
//  LSB_FIRST  0  0: first bit received lands in p_dout[WIDTH-1]; 1: lands in p_dout[0]
// PORTS
//  clk        in   1          rising-edge clock; the single clock
//  clr_n      in   1          asynchronous, active-low reset
//  s_valid    in   1          s_din carries a valid bit this cycle
//  s_din      in   1          serial data bit
//  s_sof      in   1          start of frame; used only when s_valid=1
//  ovf_clr    in   1          synchronous clear of the overflow flag
//  p_dout     out  WIDTH      assembled word; stable while p_valid=1
//  p_valid    out  1          output buffer holds an unconsumed word
//  p_ready    in   1          consumer accepts the word when p_valid & p_ready
//  busy       out  1          a partial word is in progress (1..WIDTH-1 bits held)
//  overflow   out  1          sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (clr_n=0, async): p_dout=0, p_valid=0, busy=0, overflow=0, bit count=0, state IDLE.
//  FSM states:
//   IDLE: no bits held. Goes to SHIFT on s_valid.
//   SHIFT: 1..WIDTH-1 bits held. busy=1 only in this state.
//  Bit accept: each cycle with s_valid=1, one bit shifts into the internal shift register.
//   Shift direction follows LSB_FIRST.
//  s_sof=1 with s_valid=1: any partial word is discarded silently (no overflow).
//   That bit becomes bit 0 of a new word, and the count becomes 1.
//  s_sof=1 with s_valid=0: ignored.
//  Word complete: on the cycle the WIDTH-th bit is accepted:
//   - output free: buffer loads on that edge, p_valid=1 from the next cycle
//     (latency: 1 clk after the last bit's edge).
//   - output free means p_valid=0, or p_valid & p_ready in the same cycle.
//     The pop and the load happen together, so there is no bubble.
//   - output full and not popping: the word is dropped and overflow is set.
//     The buffer keeps its old word unchanged.
//   - the FSM returns to IDLE and the count goes to 0 in both cases.
//  p_valid clears on the edge where p_valid & p_ready, unless a new word loads on the same edge.
//  p_ready with p_valid=0 has no effect. p_dout changes only on a load.
//  overflow stays set until ovf_clr=1 or reset.
//   ovf_clr and a new overflow in the same cycle: overflow stays 1 (set wins).
//  Back-to-back words: with s_valid held at 1, words complete every WIDTH cycles, with no dead cycle.
//  Count is $clog2(WIDTH+1) bits and never exceeds WIDTH-1 when registered.
//  Reset mid-word or while p_valid=1: all state is lost immediately. No word is emitted after release.
// STRUCTURE
//  Shared package (shift_reg_pkg): FSM state encoding constants ST_IDLE/ST_SHIFT.
//  Single sub-module deser_bit_counter:
//   - count, increment on s_valid, reload to 1 on s_sof, clear on word complete;
//   - drives the last-bit strobe.
//  The shift register, output buffer, overflow logic and FSM live in the top module.
// TESTING (WIDTH=4)
//  1. LSB_FIRST=0, serial 1,1,0,1 on consecutive cycles.
//     -> p_valid=1 one clk after the 4th bit, p_dout=4'b1101.
//  2. LSB_FIRST=1, same bits -> p_dout=4'b1011. busy=1 after bits 1-3 and 0 after bit 4.
//  3. Bits 1,0 then s_sof with bits 0,1,1,1.
//     -> one word 4'b0111, overflow stays 0.
//  4. p_ready=0, send 1101 then 0011.
//     -> p_dout stays 1101, overflow=1 after the 8th bit. ovf_clr then clears it.
//  5. p_ready=1, continuous s_valid, words 1101,0011,1111.
//     -> three p_valid pulses exactly 4 clks apart, no overflow.
//  6. clr_n low after 2 bits, and separately with p_valid=1.
//     -> all outputs 0 asynchronously. The next 4 bits form a clean word.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial-to-parallel receive path.
// Holds the deserializer FSM state encoding.
package shift_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } deser_state_e;

endpackage

// File: rtl/deser_bit_counter.sv
// Bit counter for the deserializer.
// Counts accepted bits and strobes when the final bit of a word arrives.
module deser_bit_counter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic s_valid_i,
    input  logic s_sof_i,
    output logic last_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_s;

    // Next count: a start-of-frame bit restarts at one; the final bit wraps to zero.
    always_comb begin
        cnt_d  = cnt_q;
        last_s = 1'b0;
        if (s_valid_i) begin
            if (s_sof_i) begin
                cnt_d = CW'(1);
            end else if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d  = '0;
                last_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = last_s;

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a qualified bit
// stream and offers them through a one-entry valid/ready buffer with overrun flag.
module serial_word_deserializer
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             s_valid,
    input  logic             s_din,
    input  logic             s_sof,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overflow
);

    deser_state_e     state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, shifted_s;
    logic [WIDTH-1:0] p_dout_q, p_dout_d;
    logic             p_valid_q, p_valid_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             last_s;
    logic             free_s;
    logic             load_s;
    logic             pop_s;

    deser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk       (clk),
        .clr_n     (clr_n),
        .s_valid_i (s_valid),
        .s_sof_i   (s_sof),
        .last_o    (last_s)
    );

    // Shift value including the current bit; a frame start drops earlier bits.
    always_comb begin
        shifted_s = sr_q;
        if (LSB_FIRST) begin
            if (s_sof) begin
                shifted_s = {s_din, {(WIDTH-1){1'b0}}};
            end else begin
                shifted_s = {s_din, sr_q[WIDTH-1:1]};
            end
        end else begin
            if (s_sof) begin
                shifted_s = {{(WIDTH-1){1'b0}}, s_din};
            end else begin
                shifted_s = {sr_q[WIDTH-2:0], s_din};
            end
        end
    end

    // FSM next state: IDLE holds no bits, SHIFT holds a partial word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop_s  = p_valid_q & p_ready;
    assign free_s = ~p_valid_q | p_ready;
    assign load_s = last_s & free_s;

    // Datapath next values; a pop and a load on the same edge leave p_valid set.
    always_comb begin
        sr_d      = sr_q;
        p_dout_d  = p_dout_q;
        p_valid_d = p_valid_q;
        ovf_d     = ovf_q;
        busy_d    = (state_d == ST_SHIFT);
        if (s_valid) begin
            sr_d = shifted_s;
        end else begin
            sr_d = sr_q;
        end
        if (load_s) begin
            p_dout_d  = shifted_s;
            p_valid_d = 1'b1;
        end else if (pop_s) begin
            p_valid_d = 1'b0;
        end else begin
            p_valid_d = p_valid_q;
        end
        if (last_s && !free_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            p_dout_q  <= '0;
            p_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            p_dout_q  <= p_dout_d;
            p_valid_q <= p_valid_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign p_dout   = p_dout_q;
    assign p_valid  = p_valid_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Randomized and directed bench for serial_word_deserializer (WIDTH=4),
// driving an MSB-first and an LSB-first instance with the same stream.
module tb_serial_word_deserializer;

    logic       clk;
    logic       clr_n;
    logic       s_valid, s_din, s_sof, ovf_clr, p_ready;
    logic [3:0] p_dout_a, p_dout_b;
    logic       p_valid_a, p_valid_b, busy_a, busy_b, overflow_a, overflow_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit         mbits[$];
    logic [3:0] m_dout_a, m_dout_b;
    logic       m_valid, m_busy, m_ovf;

    serial_word_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .clr_n(clr_n), .s_valid(s_valid), .s_din(s_din), .s_sof(s_sof),
        .ovf_clr(ovf_clr), .p_dout(p_dout_a), .p_valid(p_valid_a), .p_ready(p_ready),
        .busy(busy_a), .overflow(overflow_a)
    );

    serial_word_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .clr_n(clr_n), .s_valid(s_valid), .s_din(s_din), .s_sof(s_sof),
        .ovf_clr(ovf_clr), .p_dout(p_dout_b), .p_valid(p_valid_b), .p_ready(p_ready),
        .busy(busy_b), .overflow(overflow_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: bits collected in arrival order; a full word is packed arithmetically.
    task automatic model_edge();
        logic pop, free, ld, nov;
        logic [3:0] wa, wb;
        pop = m_valid && p_ready;
        free = !m_valid || p_ready;
        ld = 1'b0;
        nov = 1'b0;
        wa = 4'd0;
        wb = 4'd0;
        if (s_valid) begin
            if (s_sof) mbits.delete();
            mbits.push_back(s_din);
            if (mbits.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    wa[3-i] = mbits[i];
                    wb[i]   = mbits[i];
                end
                if (free) begin
                    ld = 1'b1;
                    m_dout_a = wa;
                    m_dout_b = wb;
                end else begin
                    nov = 1'b1;
                end
                mbits.delete();
            end
        end
        if (ld) m_valid = 1'b1;
        else if (pop) m_valid = 1'b0;
        if (nov) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_busy = (mbits.size() != 0);
    endtask

    task automatic check_all();
        check_eq("p_valid_a", p_valid_a, m_valid);
        check_eq("p_valid_b", p_valid_b, m_valid);
        check_eq("p_dout_a", p_dout_a, m_dout_a);
        check_eq("p_dout_b", p_dout_b, m_dout_b);
        check_eq("busy_a", busy_a, m_busy);
        check_eq("busy_b", busy_b, m_busy);
        check_eq("overflow_a", overflow_a, m_ovf);
        check_eq("overflow_b", overflow_b, m_ovf);
    endtask

    task automatic step(input logic v, input logic d, input logic sof, input logic rdy, input logic oc);
        s_valid = v;
        s_din   = d;
        s_sof   = sof;
        p_ready = rdy;
        ovf_clr = oc;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_din   = 1'b0;
        s_sof   = 1'b0;
        p_ready = 1'b0;
        ovf_clr = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        check_eq("rst_p_valid", {p_valid_a, p_valid_b}, 2'b00);
        check_eq("rst_p_dout", {p_dout_a, p_dout_b}, 8'h00);
        check_eq("rst_busy", {busy_a, busy_b}, 2'b00);
        check_eq("rst_overflow", {overflow_a, overflow_b}, 2'b00);
        mbits.delete();
        m_dout_a = 4'd0;
        m_dout_b = 4'd0;
        m_valid  = 1'b0;
        m_busy   = 1'b0;
        m_ovf    = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends w[3] first, then w[2], w[1], w[0].
    task automatic send_word(input logic [3:0] w, input logic rdy);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, w[i], 1'b0, rdy, 1'b0);
        end
    endtask

    initial begin
        int pulses[$];
        logic [3:0] bits4;
        clr_n = 1'b0;
        do_reset();

        // Word assembly in both bit orders, with latency and busy.
        bits4 = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits4[i], 1'b0, 1'b0, 1'b0);
            if (i > 0) begin
                check_eq("t2_busy_mid", busy_b, 1'b1);
                check_eq("t1_no_valid_early", p_valid_a, 1'b0);
            end
        end
        check_eq("t1_p_valid", p_valid_a, 1'b1);
        check_eq("t1_p_dout", p_dout_a, 4'b1101);
        check_eq("t2_p_dout", p_dout_b, 4'b1011);
        check_eq("t2_busy_end", busy_b, 1'b0);

        // Frame restart discards the partial word.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t3_no_valid_early", p_valid_a, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t3_p_dout", p_dout_a, 4'b0111);
        check_eq("t3_overflow", overflow_a, 1'b0);

        // Overrun: buffer keeps the first word, flag set, then cleared.
        do_reset();
        send_word(4'b1101, 1'b0);
        send_word(4'b0011, 1'b0);
        check_eq("t4_p_dout", p_dout_a, 4'b1101);
        check_eq("t4_overflow", overflow_a, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t4_ovf_clr", overflow_a, 1'b0);

        // Back-to-back words with a ready consumer.
        do_reset();
        pulses.delete();
        for (int w = 0; w < 3; w++) begin
            bits4 = (w == 0) ? 4'b1101 : ((w == 1) ? 4'b0011 : 4'b1111);
            for (int i = 3; i >= 0; i--) begin
                step(1'b1, bits4[i], 1'b0, 1'b1, 1'b0);
                if (p_valid_a) pulses.push_back(cyc);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (p_valid_a) pulses.push_back(cyc);
        end
        check_eq("t5_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check_eq("t5_gap1", pulses[1] - pulses[0], 4);
            check_eq("t5_gap2", pulses[2] - pulses[1], 4);
        end
        check_eq("t5_overflow", overflow_a, 1'b0);

        // Reset mid-word and with a word pending.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_word(4'b1001, 1'b0);
        check_eq("t6_clean_word", p_dout_a, 4'b1001);
        do_reset();
        send_word(4'b0110, 1'b0);
        check_eq("t6_word_after", p_dout_b, 4'b0110);

        // Randomized traffic against the reference.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
